// File: rtl/imem_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imem_fetch_pkg
// Shared types and constants for the instruction-fetch controller.
//   fetch_state_e : controller FSM states (FAULT is only reachable when the
//                   build defines IMEM_FETCH_BOUNDS_EN)
//   fetch_entry_t : one prefetch-queue entry {pc, instr}
//   INSTR_BYTES   : PC increment per fetched word
//   DEFAULT_RESET_PC : default fetch PC after reset
// ---------------------------------------------------------------------------
package imem_fetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bundles the fetch controller's memory, redirect and decode-side signals.
//   slave  : view used by imem_fetch_ctrl
//   master : view used by the surrounding core / testbench
// Signals:
//   fetch_en        enable level for fetching
//   imem_addr       byte address to instruction memory
//   imem_data       combinational word returned for imem_addr
//   redirect_valid  one-cycle re-steer pulse
//   redirect_pc     new fetch PC (bits [1:0] ignored)
//   instr_valid     queue head valid
//   instr_ready     decode accepts head
//   instr           head instruction word
//   instr_pc        PC of head instruction
//   fault           sticky out-of-range fetch flag (0 unless bounds build)
// ---------------------------------------------------------------------------
interface imem_fetch_ctrl_if;

  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;

  modport slave (
    input  fetch_en, imem_data, redirect_valid, redirect_pc, instr_ready,
    output imem_addr, instr_valid, instr, instr_pc, fault
  );

  modport master (
    output fetch_en, imem_data, redirect_valid, redirect_pc, instr_ready,
    input  imem_addr, instr_valid, instr, instr_pc, fault
  );

endinterface

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of {pc, instr} entries feeding the decode stage.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   push_i         write push_entry_i (accepted if not full or popping)
//   pop_i          remove head (ignored when empty)
//   flush_i        empty the queue; wins over push
//   push_entry_i   entry to write
//   head_o         current head; holds the last presented head when empty
//   valid_o        queue non-empty
//   full_o         queue holds DEPTH entries
// ---------------------------------------------------------------------------
module fetch_queue
  import imem_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_entry_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    last_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            pop_eff;
  logic            push_eff;

  assign valid_o  = (count_q != '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign pop_eff  = pop_i && valid_o;
  assign push_eff = push_i && (!full_o || pop_eff);

  // When empty the head mirrors the last word shown so instr/instr_pc stay stable.
  assign head_o = valid_o ? mem_q[rd_ptr_q] : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      last_q <= head_o;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_eff) begin
          mem_q[wr_ptr_q] <= push_entry_i;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (pop_eff) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        count_q <= count_q + CW'(push_eff) - CW'(pop_eff);
      end
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-fetch controller: owns the fetch PC, drives the instruction
// memory address, captures {pc, word} into a prefetch queue and presents the
// head to decode over valid/ready. Redirects flush the queue and re-steer.
// Optional bounds checking is compiled in with the macro IMEM_FETCH_BOUNDS_EN:
// a fetch at fpc with fpc+3 >= MEM_BYTES is suppressed and sets a sticky
// fault until the next redirect.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    imem_fetch_ctrl_if.slave (memory, redirect, decode and fault)
// Parameters:
//   RESET_PC    fetch PC after reset
//   FIFO_DEPTH  prefetch queue depth (power of two, >= 2)
//   MEM_BYTES   memory size in bytes, used by the bounds check only
// ---------------------------------------------------------------------------
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MEM_BYTES  = 2500
) (
  input logic              clk,
  input logic              rst_n,
  imem_fetch_ctrl_if.slave bus
);

  //  state | meaning
  //  IDLE  | not fetching; queue may still drain, redirects still update fpc
  //  RUN   | fetching one word per cycle while the queue has room
  //  FAULT | out-of-range fetch seen; fault held until a redirect

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (MEM_BYTES < INSTR_BYTES) begin : g_bad_mem
      $error("MEM_BYTES must hold at least one instruction");
    end
  endgenerate

  fetch_state_e state_q;
  logic [31:0]  fpc_q;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         q_valid;
  logic         q_full;
  logic         pop;
  logic         fetch_req;
  logic         push;

  assign pop        = q_valid && bus.instr_ready;
  // A full queue can still take a word when the head leaves the same cycle.
  assign fetch_req  = (state_q == RUN) && bus.fetch_en && !bus.redirect_valid
                      && (!q_full || pop);
  assign push_entry = '{pc: fpc_q, instr: bus.imem_data};

`ifdef IMEM_FETCH_BOUNDS_EN
  logic fault_q;
  logic oob;
  logic fault_hit;

  // 33-bit compare so addresses near 2^32 do not wrap into range.
  assign oob       = ({1'b0, fpc_q} + 33'd3) >= 33'(MEM_BYTES);
  assign push      = fetch_req && !oob;
  assign fault_hit = fetch_req && oob;
  assign bus.fault = fault_q;
`else
  assign push      = fetch_req;
  assign bus.fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
`ifdef IMEM_FETCH_BOUNDS_EN
      fault_q <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      fpc_q   <= {bus.redirect_pc[31:2], 2'b00};
      state_q <= bus.fetch_en ? RUN : IDLE;
`ifdef IMEM_FETCH_BOUNDS_EN
      fault_q <= 1'b0;
`endif
    end else begin
      if (push) begin
        fpc_q <= fpc_q + 32'(INSTR_BYTES);
      end
      case (state_q)
        IDLE: begin
          if (bus.fetch_en) state_q <= RUN;
        end
        RUN: begin
`ifdef IMEM_FETCH_BOUNDS_EN
          if (fault_hit) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else if (!bus.fetch_en) begin
            state_q <= IDLE;
          end
`else
          if (!bus.fetch_en) state_q <= IDLE;
`endif
        end
`ifdef IMEM_FETCH_BOUNDS_EN
        FAULT: state_q <= FAULT;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (bus.redirect_valid),
    .push_entry_i (push_entry),
    .head_o       (head),
    .valid_o      (q_valid),
    .full_o       (q_full)
  );

  assign bus.imem_addr   = fpc_q;
  assign bus.instr_valid = q_valid;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Self-checking bench for imem_fetch_ctrl. A queue-based reference model
// advances on each rising edge; a checker compares every falling edge.
// Directed sequences pin the model with literal expectations, then random
// traffic runs. Works with or without IMEM_FETCH_BOUNDS_EN.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  localparam int DEPTH = 2;
`ifdef IMEM_FETCH_BOUNDS_EN
  localparam int TB_MEM = 16;
  localparam bit BOUNDS = 1'b1;
`else
  localparam int TB_MEM = 2500;
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  imem_fetch_ctrl_if ifc ();

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH),
    .MEM_BYTES  (TB_MEM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h11;
      32'd4:   return 32'h22;
      32'd8:   return 32'h33;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  assign ifc.imem_data = mem_word(ifc.imem_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the queue contents, the fetch PC, and whether fetching
  // is active or stopped by a fault.
  logic [63:0] mq[$];
  logic [31:0] m_fpc     = 32'h0;
  bit          m_running = 1'b0;
  bit          m_faulted = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int n;
    bit pop_now;
    bit want;
    if (!rst_n) begin
      mq.delete();
      m_fpc     = 32'h0;
      m_running = 1'b0;
      m_faulted = 1'b0;
    end else begin
      n       = mq.size();
      pop_now = (n > 0) && ifc.instr_ready;
      if (ifc.redirect_valid) begin
        mq.delete();
        m_fpc     = {ifc.redirect_pc[31:2], 2'b00};
        m_faulted = 1'b0;
        m_running = ifc.fetch_en;
      end else begin
        want = m_running && ifc.fetch_en && (n < DEPTH || pop_now);
        if (pop_now) void'(mq.pop_front());
        if (want) begin
          if (BOUNDS && ({32'h0, m_fpc} + 64'd3 >= 64'(TB_MEM))) begin
            m_faulted = 1'b1;
            m_running = 1'b0;
          end else begin
            mq.push_back({m_fpc, mem_word(m_fpc)});
            m_fpc = m_fpc + 32'd4;
          end
        end
        if (!m_faulted) m_running = ifc.fetch_en;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("instr_valid", {31'b0, ifc.instr_valid}, {31'b0, mq.size() > 0});
      if (mq.size() > 0) begin
        check("instr", ifc.instr, mq[0][31:0]);
        check("instr_pc", ifc.instr_pc, mq[0][63:32]);
      end
      check("imem_addr", ifc.imem_addr, m_fpc);
      check("fault", {31'b0, ifc.fault}, {31'b0, m_faulted});
    end
  end

  task automatic step(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] pc);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = pc;
    step();
    ifc.redirect_valid = 1'b0;
  endtask

  initial begin
    ifc.fetch_en       = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'h0;
    ifc.instr_ready    = 1'b0;
    rst_n              = 1'b1;
    #1 rst_n = 1'b0;
    step(2);
    check("rst_addr", ifc.imem_addr, 32'h0);
    check("rst_valid", {31'b0, ifc.instr_valid}, 32'h0);
    check("rst_instr", ifc.instr, 32'h0);
    check("rst_pc", ifc.instr_pc, 32'h0);
    check("rst_fault", {31'b0, ifc.fault}, 32'h0);
    rst_n = 1'b1;
    step();

    // Startup: valid two edges after fetch_en, then back-to-back stream.
    ifc.fetch_en    = 1'b1;
    ifc.instr_ready = 1'b1;
    step();
    check("start_valid0", {31'b0, ifc.instr_valid}, 32'h0);
    step();
    check("start_i0", ifc.instr, 32'h11);
    check("start_pc0", ifc.instr_pc, 32'h0);
    step();
    check("start_i1", ifc.instr, 32'h22);
    check("start_pc1", ifc.instr_pc, 32'h4);
    step();
    check("start_i2", ifc.instr, 32'h33);
    check("start_pc2", ifc.instr_pc, 32'h8);

    // Backpressure: restart at 0, hold ready low, queue fills to 2.
    ifc.instr_ready = 1'b0;
    redirect(32'h0);
    step(5);
    check("bp_addr", ifc.imem_addr, 32'h8);
    check("bp_pc", ifc.instr_pc, 32'h0);
    ifc.instr_ready = 1'b1;
    step();
    check("bp_pc1", ifc.instr_pc, 32'h4);
    step();
    check("bp_pc2", ifc.instr_pc, 32'h8);

`ifndef IMEM_FETCH_BOUNDS_EN
    // Redirect into a full queue with a simultaneous pop.
    ifc.instr_ready = 1'b0;
    step(3);
    ifc.instr_ready = 1'b1;
    redirect(32'h43);
    check("rd_valid", {31'b0, ifc.instr_valid}, 32'h0);
    check("rd_addr", ifc.imem_addr, 32'h40);
    step();
    check("rd_pc", ifc.instr_pc, 32'h40);
    check("rd_instr", ifc.instr, mem_word(32'h40));

    // Address wrap.
    redirect(32'hFFFF_FFFC);
    step();
    check("wrap_pc0", ifc.instr_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc1", ifc.instr_pc, 32'h0);

    // fetch_en drop with two queued entries.
    ifc.instr_ready = 1'b0;
    redirect(32'h100);
    step(3);
    ifc.fetch_en    = 1'b0;
    ifc.instr_ready = 1'b1;
    step();
    check("drop_pc", ifc.instr_pc, 32'h104);
    step();
    check("drop_valid", {31'b0, ifc.instr_valid}, 32'h0);
    check("drop_addr", ifc.imem_addr, 32'h108);
    step(2);
    check("drop_hold", ifc.imem_addr, 32'h108);
    ifc.fetch_en = 1'b1;
    step(2);
    check("resume_pc", ifc.instr_pc, 32'h108);
`else
    // Bounds: 0,4,8,12 delivered, 16 faults, redirect clears.
    redirect(32'h0);
    step();
    check("bnd_pc0", ifc.instr_pc, 32'h0);
    step();
    check("bnd_pc4", ifc.instr_pc, 32'h4);
    step();
    check("bnd_pc8", ifc.instr_pc, 32'h8);
    step();
    check("bnd_pc12", ifc.instr_pc, 32'hC);
    step();
    check("bnd_fault", {31'b0, ifc.fault}, 32'h1);
    check("bnd_valid", {31'b0, ifc.instr_valid}, 32'h0);
    step(2);
    check("bnd_sticky", {31'b0, ifc.fault}, 32'h1);
    redirect(32'h0);
    check("bnd_clear", {31'b0, ifc.fault}, 32'h0);
    step();
    check("bnd_resume", ifc.instr_pc, 32'h0);
`endif

    // Asynchronous reset mid-operation.
    step(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", ifc.imem_addr, 32'h0);
    check("arst_valid", {31'b0, ifc.instr_valid}, 32'h0);
    check("arst_instr", ifc.instr, 32'h0);
    check("arst_fault", {31'b0, ifc.fault}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ifc.fetch_en       = ($urandom_range(0, 7) != 0);
      ifc.instr_ready    = ($urandom_range(0, 2) != 0);
      ifc.redirect_valid = ($urandom_range(0, 24) == 0);
`ifdef IMEM_FETCH_BOUNDS_EN
      ifc.redirect_pc    = $urandom_range(0, 31);
`else
      ifc.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                      : $urandom();
`endif
      step();
    end
    ifc.redirect_valid = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
